// File: rtl/raw_readout_ctrl.sv
// raw_readout_ctrl: sequences the raw-hit delay buffer and turns each L1A into a window of delayed frames.
// Latency: first ro_valid 2 cycles after the l1a cycle; busy drops delay+2 cycles after FILL is entered.
// Backpressure: none; a window streams win back-to-back frames, and L1As that cannot be served are flagged on l1a_lost.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   run_en, cfg_delay, cfg_win,   run level, buffer delay, window length (0 -> 1, > WIN_MAX -> WIN_MAX),
//   cfg_load, l1a                 config-load/restart pulse, level-1 accept pulse
//   raw_we, raw_trig_stop,        buffer write enable, pointer reset/hold, latched delay
//   raw_delay, raw_dout           and the buffer's output frame
//   ro_data, ro_valid, ro_first,  readout stream: registered frame, valid, window start/end flags,
//   ro_last, ro_bin               frame index within the window
//   busy, l1a_lost                not in RUN; one-cycle pulse (the cycle after) for each dropped L1A
//
// Optional feature: RAW_RO_L1A_QUEUE_EN adds a one-deep pending-L1A flag so an L1A that
// arrives during a window starts the next window back-to-back instead of being dropped.

module raw_readout_ctrl #(
    parameter  int W       = 288,
    parameter  int WIN_MAX = 16,
    localparam int BW      = $clog2(WIN_MAX) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_en,
    input  logic [7:0]    cfg_delay,
    input  logic [4:0]    cfg_win,
    input  logic          cfg_load,
    input  logic          l1a,
    output logic          raw_we,
    output logic          raw_trig_stop,
    output logic [7:0]    raw_delay,
    input  logic [W-1:0]  raw_dout,
    output logic [W-1:0]  ro_data,
    output logic          ro_valid,
    output logic          ro_first,
    output logic          ro_last,
    output logic [BW-1:0] ro_bin,
    output logic          busy,
    output logic          l1a_lost
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_READ} state_t;

    localparam logic [4:0] L_WIN_MAX = 5'(WIN_MAX);

    state_t        r_state;
    logic [8:0]    r_fill_cnt;
    logic [BW-1:0] r_bin;
    logic [BW-1:0] r_win;
    logic [7:0]    r_delay;
    logic          r_we;
    logic          r_trig_stop;
    logic          r_busy;
    logic          r_lost;
    logic [W-1:0]  r_ro_data;
    logic          r_ro_valid;
    logic          r_ro_first;
    logic          r_ro_last;
    logic [BW-1:0] r_ro_bin;
`ifdef RAW_RO_L1A_QUEUE_EN
    logic          r_pending;
`endif

    logic [BW-1:0] w_win_clamp;
    logic          w_bin_last;
    logic          w_fill_done;

    always_comb begin
        w_win_clamp = BW'(cfg_win);
        if (cfg_win == 5'd0)
            w_win_clamp = BW'(1);
        else if (cfg_win > L_WIN_MAX)
            w_win_clamp = BW'(WIN_MAX);
    end

    assign w_bin_last  = (r_bin == r_win - 1'b1);
    // delay+2 FILL cycles: counter runs 0..delay+1 and leaves on the last value.
    assign w_fill_done = (r_fill_cnt == {1'b0, r_delay} + 9'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fill_cnt  <= '0;
            r_bin       <= '0;
            r_win       <= BW'(1);
            r_delay     <= '0;
            r_we        <= 1'b0;
            r_trig_stop <= 1'b1;
            r_busy      <= 1'b1;
            r_lost      <= 1'b0;
            r_ro_data   <= '0;
            r_ro_valid  <= 1'b0;
            r_ro_first  <= 1'b0;
            r_ro_last   <= 1'b0;
            r_ro_bin    <= '0;
`ifdef RAW_RO_L1A_QUEUE_EN
            r_pending   <= 1'b0;
`endif
        end else begin
            // Stream flags are single-cycle unless a READ cycle re-asserts them.
            r_ro_valid <= 1'b0;
            r_ro_first <= 1'b0;
            r_ro_last  <= 1'b0;
            r_lost     <= 1'b0;

            if (cfg_load) begin
                r_delay <= cfg_delay;
                r_win   <= w_win_clamp;
            end

            if (!run_en || cfg_load) begin
                // Stop or restart: any window is abandoned without ro_last; the buffer
                // pointer is held for (at least) this one cycle.
                r_state     <= run_en ? S_FILL : S_IDLE;
                r_fill_cnt  <= '0;
                r_we        <= run_en;
                r_trig_stop <= 1'b1;
                r_busy      <= 1'b1;
                r_lost      <= l1a;
`ifdef RAW_RO_L1A_QUEUE_EN
                r_pending   <= 1'b0;
`endif
            end else begin
                r_we        <= 1'b1;
                r_trig_stop <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_FILL;
                        r_fill_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_lost     <= l1a;
                    end
                    S_FILL: begin
                        r_lost <= l1a;
                        if (w_fill_done) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b0;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 9'd1;
                        end
                    end
                    S_RUN: begin
                        if (l1a) begin
                            r_state <= S_READ;
                            r_bin   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_READ: begin
                        r_ro_data  <= raw_dout;
                        r_ro_valid <= 1'b1;
                        r_ro_bin   <= r_bin;
                        r_ro_first <= (r_bin == '0);
                        r_ro_last  <= w_bin_last;
                        r_bin      <= r_bin + 1'b1;
`ifdef RAW_RO_L1A_QUEUE_EN
                        if (w_bin_last) begin
                            // An l1a on the last bin counts as pending and is consumed at once.
                            if (r_pending || l1a) begin
                                r_bin     <= '0;
                                r_pending <= 1'b0;
                                r_lost    <= r_pending && l1a;
                            end else begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                            end
                        end else if (l1a) begin
                            r_lost    <= r_pending;
                            r_pending <= 1'b1;
                        end
`else
                        r_lost <= l1a;
                        if (w_bin_last) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b0;
                        end
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign raw_we        = r_we;
    assign raw_trig_stop = r_trig_stop;
    assign raw_delay     = r_delay;
    assign ro_data       = r_ro_data;
    assign ro_valid      = r_ro_valid;
    assign ro_first      = r_ro_first;
    assign ro_last       = r_ro_last;
    assign ro_bin        = r_ro_bin;
    assign busy          = r_busy;
    assign l1a_lost      = r_lost;

endmodule

// File: tb/tb_raw_readout_ctrl.sv
// tb_raw_readout_ctrl: directed bench for raw_readout_ctrl with hand-derived expectations.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_raw_readout_ctrl;

    localparam int W  = 288;
    localparam int BW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run_en;
    logic [7:0]    cfg_delay;
    logic [4:0]    cfg_win;
    logic          cfg_load;
    logic          l1a;
    logic          raw_we;
    logic          raw_trig_stop;
    logic [7:0]    raw_delay;
    logic [W-1:0]  raw_dout;
    logic [W-1:0]  ro_data;
    logic          ro_valid;
    logic          ro_first;
    logic          ro_last;
    logic [BW-1:0] ro_bin;
    logic          busy;
    logic          l1a_lost;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    logic [W-1:0]  prev_dout;

    raw_readout_ctrl #(.W(W), .WIN_MAX(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_en        (run_en),
        .cfg_delay     (cfg_delay),
        .cfg_win       (cfg_win),
        .cfg_load      (cfg_load),
        .l1a           (l1a),
        .raw_we        (raw_we),
        .raw_trig_stop (raw_trig_stop),
        .raw_delay     (raw_delay),
        .raw_dout      (raw_dout),
        .ro_data       (ro_data),
        .ro_valid      (ro_valid),
        .ro_first      (ro_first),
        .ro_last       (ro_last),
        .ro_bin        (ro_bin),
        .busy          (busy),
        .l1a_lost      (l1a_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] mk_frame(input int c);
        logic [W-1:0] f;
        for (int j = 0; j < 9; j++)
            f[j*32 +: 32] = 32'(c) * 32'd9 + 32'(j) + (32'h1000_0000 * 32'(j + 1));
        return f;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick;
        prev_dout = raw_dout;
        @(posedge clk);
        #1;
        cyc++;
        raw_dout = mk_frame(cyc);
    endtask

    task automatic wait_run;
        for (int i = 0; i < 40 && busy; i++)
            tick();
        chk("fill_done_busy", busy, 1'b0);
    endtask

    // l1a at relative cycle 0 (and optionally at l1a2); expects nfr frames of a win-frame
    // window pattern at observation 2..nfr+1, and a lost pulse the cycle after l1a2 if drop2.
    task automatic window(input int l1a2, input int nfr, input int win, input bit drop2);
        for (int c = 0; c <= nfr + 1; c++) begin
            int o;
            int k;
            o   = c + 1;
            l1a = (c == 0) || (c == l1a2);
            tick();
            l1a = 1'b0;
            k   = o - 2;
            if (o >= 2 && o <= nfr + 1) begin
                chk("ro_valid", ro_valid, 1'b1);
                chk("ro_bin", ro_bin, BW'(k % win));
                chk("ro_first", ro_first, (k % win) == 0);
                chk("ro_last", ro_last, (k % win) == win - 1);
                chk("ro_data", ro_data, prev_dout);
            end else begin
                chk("ro_valid_idle", ro_valid, 1'b0);
            end
            chk("l1a_lost", l1a_lost, drop2 && (o == l1a2 + 1));
        end
        chk("busy_after_win", busy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b1;
        run_en    = 1'b0;
        cfg_delay = 8'd0;
        cfg_win   = 5'd0;
        cfg_load  = 1'b0;
        l1a       = 1'b0;
        raw_dout  = mk_frame(0);
        prev_dout = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", raw_we, 1'b0);
        chk("rst_trig_stop", raw_trig_stop, 1'b1);
        chk("rst_delay", raw_delay, 8'd0);
        chk("rst_ro_data", ro_data, '0);
        chk("rst_ro_valid", ro_valid, 1'b0);
        chk("rst_ro_bin", ro_bin, '0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_lost", l1a_lost, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle_trig_stop", raw_trig_stop, 1'b1);

        // 1: load delay 5, fill takes 7 cycles, L1A in FILL is dropped.
        run_en    = 1'b1;
        cfg_delay = 8'd5;
        cfg_win   = 5'd4;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
        chk("load_trig_stop", raw_trig_stop, 1'b1);
        chk("load_we", raw_we, 1'b1);
        chk("load_delay", raw_delay, 8'd5);
        chk("fill_busy0", busy, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            l1a = (i == 3);
            tick();
            chk("fill_busy", busy, 1'b1);
            chk("fill_we", raw_we, 1'b1);
            chk("fill_trig_stop", raw_trig_stop, 1'b0);
            chk("fill_lost", l1a_lost, i == 3);
        end
        l1a = 1'b0;
        tick();
        chk("run_busy", busy, 1'b0);
        chk("run_we", raw_we, 1'b1);

        // 2: window of 4.
        window(-1, 4, 4, 1'b0);

        // 3: window 0 -> 1 frame; window 31 -> 16 frames.
        cfg_win  = 5'd0;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_run();
        window(-1, 1, 1, 1'b0);
        cfg_win  = 5'd31;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_run();
        window(-1, 16, 16, 1'b0);

        // 4: second L1A two cycles after the first.
        cfg_win  = 5'd4;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_run();
`ifdef RAW_RO_L1A_QUEUE_EN
        window(2, 8, 4, 1'b0);
`else
        window(2, 4, 4, 1'b1);
`endif

        // 5: cfg_load while ro_bin shows 2 aborts the window and refills with delay 3.
        l1a = 1'b1;
        tick();
        l1a = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_valid", ro_valid, 1'b1);
        chk("abort_pre_bin", ro_bin, BW'(2));
        cfg_delay = 8'd3;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
        chk("abort_valid", ro_valid, 1'b0);
        chk("abort_last", ro_last, 1'b0);
        chk("abort_trig_stop", raw_trig_stop, 1'b1);
        chk("abort_delay", raw_delay, 8'd3);
        chk("abort_busy", busy, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("refill_trig_stop", raw_trig_stop, 1'b0);
            chk("refill_busy", busy, 1'b1);
            chk("refill_valid", ro_valid, 1'b0);
        end
        tick();
        chk("refill_done", busy, 1'b0);

        // 6: asynchronous reset in the middle of a window.
        l1a = 1'b1;
        tick();
        l1a = 1'b0;
        tick();
        chk("pre_rst_valid", ro_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ro_valid, 1'b0);
        chk("arst_data", ro_data, '0);
        chk("arst_bin", ro_bin, '0);
        chk("arst_busy", busy, 1'b1);
        chk("arst_trig_stop", raw_trig_stop, 1'b1);
        chk("arst_we", raw_we, 1'b0);
        chk("arst_delay", raw_delay, 8'd0);
        #20 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
